deser_share_ctrl: RTL and testbench

- Round-robin controller that shares one 1:32 deserializer (ports datain, validIn, dataout[31:0], validOut) between NUM_REQ serial sources.
- Grants one source at a time and streams exactly 32 bits from it into the deserializer.
- Waits for validOut, then returns the captured word tagged with its source index over a valid/ready output port.
- Sits between the serial lane front-ends and the word-level consumer.

---
 rtl/deser_share_ctrl_if.sv | 31 +++
 rtl/deser_share_ctrl.sv | 145 ++++++++++++++
 tb/tb_deser_share_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/deser_share_ctrl_if.sv
// Bundle between deser_share_ctrl and its serial sources, the shared
// deserializer and the word-level consumer.
interface deser_share_ctrl_if #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = 2
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] sdata;
    logic [NUM_REQ-1:0] gnt;
    logic               des_datain;
    logic               des_validIn;
    logic [31:0]        des_dataout;
    logic               des_validOut;
    logic [31:0]        out_data;
    logic [SRC_W-1:0]   out_src;
    logic               out_valid;
    logic               out_ready;
    logic               timeout_err;

    modport master (
        input  req, sdata, des_dataout, des_validOut, out_ready,
        output gnt, des_datain, des_validIn,
        output out_data, out_src, out_valid, timeout_err
    );

    modport slave (
        output req, sdata, des_dataout, des_validOut, out_ready,
        input  gnt, des_datain, des_validIn,
        input  out_data, out_src, out_valid, timeout_err
    );
endinterface

// File: rtl/deser_share_ctrl.sv
// Round-robin sharing of one 1:32 deserializer between NUM_REQ serial
// sources; each captured word is returned tagged with its source index.
module deser_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = 2,
    parameter int TIMEOUT = 64
) (
    input logic             clk,
    input logic             rst_n,
    deser_share_ctrl_if.master bus
);
    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRANT  = 3'd1,
        STREAM = 3'd2,
        WAIT   = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SRC_W-1:0]   idx_q, idx_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [4:0]         bcnt_q, bcnt_d;
    logic [WCW-1:0]     wcnt_q, wcnt_d;
    logic [31:0]        data_q, data_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic               ovld_q, ovld_d;
    logic               terr_q, terr_d;

    logic               found;
    logic [SRC_W-1:0]   cand;
    logic [SRC_W-1:0]   nxt_idx;
    logic [SRC_W-1:0]   ptr_inc;

    // First set request scanning upward from ptr, wrapping at NUM_REQ
    always_comb begin
        found   = 1'b0;
        cand    = '0;
        nxt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = SRC_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found   = 1'b1;
                nxt_idx = cand;
            end
        end
    end

    assign ptr_inc = (idx_q == SRC_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        data_d  = data_q;
        src_d   = src_q;
        ovld_d  = ovld_q;
        terr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = NUM_REQ'(1) << nxt_idx;
                    idx_d   = nxt_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                bcnt_d  = '0;
                state_d = STREAM;
            end
            STREAM: begin
                bcnt_d = bcnt_q + 5'd1;
                if (bcnt_q == 5'd31) begin
                    wcnt_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A word arriving on the last allowed cycle still counts
                if (bus.des_validOut) begin
                    data_d  = bus.des_dataout;
                    src_d   = idx_q;
                    ovld_d  = 1'b1;
                    gnt_d   = '0;
                    state_d = HOLD;
                end else if (wcnt_q == WCW'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    gnt_d   = '0;
                    ptr_d   = ptr_inc;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    ovld_d  = 1'b0;
                    ptr_d   = ptr_inc;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            data_q  <= '0;
            src_q   <= '0;
            ovld_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ovld_q  <= ovld_d;
            terr_q  <= terr_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.des_validIn = (state_q == STREAM);
    assign bus.des_datain  = (state_q == STREAM) ? bus.sdata[idx_q] : 1'b0;
    assign bus.out_data    = data_q;
    assign bus.out_src     = src_q;
    assign bus.out_valid   = ovld_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_deser_share_ctrl.sv
// Bench for deser_share_ctrl: behavioural sources and deserializer,
// a frame-level arbitration model, table vectors and random frames.
module tb_deser_share_ctrl;
    localparam int TMO = 64;

    typedef struct {
        logic [3:0] req;
        bit         keep;
        int         lat;
        bit         mute;
        int         rdly;
        bit         drop;
        bit         stray;
        int         exp;
        bit         fixw;
        bit         rst;
    } vec_t;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [3:0]  req_r   = '0;
    logic        ready_r = 1'b0;
    logic        stray_r = 1'b0;
    logic [3:0]  sd;
    logic [31:0] wd [4];
    logic [4:0]  bitk [4];
    logic [31:0] shreg;
    logic        vo;
    int          nb;
    int          dly;
    int          des_lat  = 1;
    bit          des_mute = 1'b0;
    int          nchk = 0;
    int          nerr = 0;
    int          mptr = 0;
    int          mid_vc;
    vec_t        tbl [13];
    vec_t        rv;

    deser_share_ctrl_if #(.NUM_REQ(4), .SRC_W(2)) bus ();

    deser_share_ctrl #(
        .NUM_REQ(4),
        .SRC_W  (2),
        .TIMEOUT(TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.req          = req_r;
    assign bus.sdata        = sd;
    assign bus.out_ready    = ready_r;
    assign bus.des_dataout  = shreg;
    assign bus.des_validOut = vo | stray_r;

    // Each source shifts its word MSB-first while granted and streaming
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) bitk[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!bus.gnt[i]) bitk[i] <= '0;
                else if (bus.des_validIn) bitk[i] <= bitk[i] + 5'd1;
            end
        end
    end

    always_comb begin
        sd = '0;
        for (int i = 0; i < 4; i++) sd[i] = wd[i][5'd31 - bitk[i]];
    end

    // Deserializer: after 32 bits, pulse validOut des_lat cycles later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nb    <= 0;
            dly   <= 0;
            vo    <= 1'b0;
            shreg <= '0;
        end else begin
            vo <= 1'b0;
            if (bus.des_validIn) begin
                shreg <= {shreg[30:0], bus.des_datain};
                nb    <= (nb == 31) ? 0 : nb + 1;
                if (nb == 31 && !des_mute) begin
                    if (des_lat == 1) vo <= 1'b1;
                    else dly <= des_lat - 1;
                end
            end
            if (dly != 0) begin
                dly <= dly - 1;
                if (dly == 1) vo <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        logic [7:0] rr;
        rr = {r, r} >> p;
        for (int i = 0; i < 4; i++) if (rr[i]) return (p + i) % 4;
        return 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        req_r   = '0;
        ready_r = 1'b0;
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_vin", bus.des_validIn, 0);
        chk("rst_din", bus.des_datain, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_src", bus.out_src, 0);
        chk("rst_oval", bus.out_valid, 0);
        chk("rst_terr", bus.timeout_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mptr  = 0;
    endtask

    task automatic run_frame(input vec_t v, input bit use_exp);
        int e, t, g, vc, w, n;
        bit done;
        logic [31:0] ew;
        logic [3:0] oh;
        e = use_exp ? v.exp : pick(v.req, mptr);
        for (int i = 0; i < 4; i++) wd[i] = $urandom;
        if (v.fixw) wd[0] = 32'hA5C3_0F71;
        ew = wd[e];
        oh = 4'b0001 << e;
        req_r    = v.req;
        des_lat  = v.lat;
        des_mute = v.mute;
        t = 0;
        while (bus.gnt == 4'b0000 && t < 4) begin
            @(negedge clk);
            t++;
        end
        chk("grant", bus.gnt, oh);
        chk("grant_setup_vin", bus.des_validIn, 0);
        if (!v.keep) req_r = req_r & ~oh;
        g = 1; vc = 0; w = 0; n = 0; done = 1'b0;
        while (!done && n < 40 + TMO) begin
            @(negedge clk);
            n++;
            stray_r = 1'b0;
            if (bus.gnt != 4'b0000) g++;
            if (bus.des_validIn) begin
                vc++;
                if (v.drop && vc == 10) req_r = '0;
                if (v.stray && vc == 5) stray_r = 1'b1;
            end else if (bus.out_valid || bus.timeout_err) begin
                done = 1'b1;
            end else if (vc > 0) begin
                w++;
            end
        end
        chk("frame_bound", done, 1);
        chk("vin_cycles", vc, 32);
        if (v.mute) begin
            chk("tmo_wait", w, TMO);
            chk("tmo_gnt_len", g, 33 + TMO);
            chk("tmo_pulse", bus.timeout_err, 1);
            chk("tmo_no_oval", bus.out_valid, 0);
            chk("tmo_gnt_off", bus.gnt, 0);
            @(negedge clk);
            chk("tmo_one_cycle", bus.timeout_err, 0);
            chk("tmo_no_oval2", bus.out_valid, 0);
        end else begin
            chk("wait_lat", w, v.lat);
            chk("gnt_len", g, 33 + v.lat);
            chk("out_data", bus.out_data, ew);
            chk("out_src", bus.out_src, e);
            chk("hold_gnt_off", bus.gnt, 0);
            if (!v.keep) req_r = '0;
            for (int k = 0; k < v.rdly; k++) begin
                @(negedge clk);
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, ew);
                chk("hold_src", bus.out_src, e);
            end
            ready_r = 1'b1;
            @(negedge clk);
            chk("accept", bus.out_valid, 0);
            ready_r = 1'b0;
        end
        mptr = (e + 1) % 4;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) wd[i] = '0;
        //           req      kp lat mu rdly dr st exp fw rs
        tbl[0]  = '{4'b0001, 0, 2,  0, 5,   0, 0, 0,  1, 0};
        tbl[1]  = '{4'b1111, 1, 1,  0, 0,   0, 0, 0,  0, 1};
        tbl[2]  = '{4'b1111, 1, 3,  0, 0,   0, 0, 1,  0, 0};
        tbl[3]  = '{4'b1111, 1, 1,  0, 0,   0, 0, 2,  0, 0};
        tbl[4]  = '{4'b1111, 1, 2,  0, 0,   0, 0, 3,  0, 0};
        tbl[5]  = '{4'b1111, 0, 4,  0, 0,   0, 0, 0,  0, 0};
        tbl[6]  = '{4'b0100, 0, 1,  0, 0,   0, 0, 2,  0, 0};
        tbl[7]  = '{4'b0101, 0, 2,  0, 1,   0, 0, 0,  0, 0};
        tbl[8]  = '{4'b0110, 0, 1,  1, 0,   0, 0, 1,  0, 0};
        tbl[9]  = '{4'b0100, 0, TMO, 0, 0,  0, 0, 2,  0, 0};
        tbl[10] = '{4'b1000, 0, 5,  0, 2,   0, 1, 3,  0, 0};
        tbl[11] = '{4'b0010, 1, 1,  0, 0,   1, 0, 1,  0, 0};
        tbl[12] = '{4'b0011, 0, 3,  0, 0,   0, 0, 0,  0, 0};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rst) do_reset();
            run_frame(tbl[i], 1'b1);
        end

        // Reset in the middle of a stream from source 3 (ptr is 1 here)
        req_r    = 4'b1000;
        des_lat  = 1;
        des_mute = 1'b0;
        @(negedge clk);
        chk("mid_grant", bus.gnt, 4'b1000);
        req_r  = '0;
        mid_vc = 0;
        for (int n = 0; n < 40 && mid_vc < 17; n++) begin
            @(negedge clk);
            if (bus.des_validIn) mid_vc++;
        end
        chk("mid_bits", mid_vc, 17);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", bus.gnt, 0);
        chk("mid_rst_vin", bus.des_validIn, 0);
        chk("mid_rst_din", bus.des_datain, 0);
        chk("mid_rst_oval", bus.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mptr  = 0;
        rv = '{4'b0011, 0, 3, 0, 0, 0, 0, 0, 0, 0};
        run_frame(rv, 1'b1);

        for (int f = 0; f < 25; f++) begin
            rv.req  = 4'($urandom_range(1, 15));
            rv.mute = ($urandom_range(0, 7) == 0);
            if (rv.mute) rv.req = 4'b0001 << $urandom_range(0, 3);
            rv.keep  = 1'b0;
            rv.lat   = $urandom_range(1, 6);
            rv.rdly  = $urandom_range(0, 3);
            rv.drop  = 1'b0;
            rv.stray = ($urandom_range(0, 1) == 1);
            rv.exp   = 0;
            rv.fixw  = 1'b0;
            rv.rst   = 1'b0;
            run_frame(rv, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
